// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer producing the DDS cfg word {on, inv, phase_inc}.
// Optional DDS_SWEEP_PINGPONG_EN: continuous sweeps reverse direction at each end instead of restarting.
module dds_sweep_ctrl #(
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [29:0]   f_start,
    input  logic [29:0]   f_step,
    input  logic          dir_down,
    input  logic [CW-1:0] n_steps,
    input  logic [CW-1:0] dwell,
    input  logic          inv,
    input  logic          continuous,
    output logic [31:0]   cfg,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] step_idx
);

    localparam int unsigned PW = 30;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   cfg_nxt;
    logic          busy_nxt, done_nxt;
    logic [CW-1:0] idx_nxt;
    logic [CW-1:0] dwell_cnt, cnt_nxt;
    logic [PW-1:0] fs_q, fs_nxt, fst_q, fst_nxt;
    logic          dn_q, dn_nxt, cont_q, cont_nxt;
    logic [CW-1:0] n_q, n_nxt, dw_q, dw_nxt;
    logic [CW-1:0] dwell_eff;

    // One saturating step: clamps to all-ones on carry, to zero on borrow.
    function automatic logic [PW-1:0] step_freq(input logic [PW-1:0] p,
                                                 input logic [PW-1:0] f,
                                                 input logic          down);
        logic [PW:0] r;
        if (down) begin
            r = {1'b0, p} - {1'b0, f};
            return r[PW] ? {PW{1'b0}} : r[PW-1:0];
        end
        r = {1'b0, p} + {1'b0, f};
        return r[PW] ? {PW{1'b1}} : r[PW-1:0];
    endfunction

    assign dwell_eff = (dwell == '0) ? CW'(1) : dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg       <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            dwell_cnt <= '0;
            fs_q      <= '0;
            fst_q     <= '0;
            dn_q      <= 1'b0;
            cont_q    <= 1'b0;
            n_q       <= '0;
            dw_q      <= '0;
        end else begin
            state     <= state_nxt;
            cfg       <= cfg_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            step_idx  <= idx_nxt;
            dwell_cnt <= cnt_nxt;
            fs_q      <= fs_nxt;
            fst_q     <= fst_nxt;
            dn_q      <= dn_nxt;
            cont_q    <= cont_nxt;
            n_q       <= n_nxt;
            dw_q      <= dw_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cfg_nxt   = cfg;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        idx_nxt   = step_idx;
        cnt_nxt   = dwell_cnt;
        fs_nxt    = fs_q;
        fst_nxt   = fst_q;
        dn_nxt    = dn_q;
        cont_nxt  = cont_q;
        n_nxt     = n_q;
        dw_nxt    = dw_q;

        case (state)
            IDLE: begin
                cfg_nxt[31] = 1'b0;
                busy_nxt    = 1'b0;
                if (start && !stop) begin
                    state_nxt = RUN;
                    busy_nxt  = 1'b1;
                    cfg_nxt   = {1'b1, inv, f_start};
                    idx_nxt   = '0;
                    cnt_nxt   = dwell_eff;
                    fs_nxt    = f_start;
                    fst_nxt   = f_step;
                    dn_nxt    = dir_down;
                    cont_nxt  = continuous;
                    n_nxt     = n_steps;
                    dw_nxt    = dwell_eff;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt   = IDLE;
                    cfg_nxt[31] = 1'b0;
                    busy_nxt    = 1'b0;
                end else if (dwell_cnt > CW'(1)) begin
                    cnt_nxt = dwell_cnt - CW'(1);
                end else if (step_idx < n_q) begin
                    cfg_nxt[PW-1:0] = step_freq(cfg[PW-1:0], fst_q, dn_q);
                    idx_nxt         = step_idx + CW'(1);
                    cnt_nxt         = dw_q;
                end else if (!cont_q) begin
                    state_nxt   = IDLE;
                    cfg_nxt[31] = 1'b0;
                    busy_nxt    = 1'b0;
                    done_nxt    = 1'b1;
                end else begin
                    cnt_nxt = dw_q;
`ifdef DDS_SWEEP_PINGPONG_EN
                    // The endpoint acts as index 0 of the reversed leg, so the first new frequency is index 1.
                    if (n_q != '0) begin
                        dn_nxt          = !dn_q;
                        cfg_nxt[PW-1:0] = step_freq(cfg[PW-1:0], fst_q, !dn_q);
                        idx_nxt         = CW'(1);
                    end else begin
                        cfg_nxt[PW-1:0] = fs_q;
                        idx_nxt         = '0;
                    end
`else
                    cfg_nxt[PW-1:0] = fs_q;
                    idx_nxt         = '0;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: time-based reference model checked every cycle, plus literal sequences.
module tb_dds_sweep_ctrl;

    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0;
    logic [29:0]   f_start = '0, f_step = '0;
    logic          dir_down = 1'b0, inv = 1'b0, continuous = 1'b0;
    logic [CW-1:0] n_steps = '0, dwell = '0;
    logic [31:0]   cfg;
    logic          busy, done;
    logic [CW-1:0] step_idx;

    int n_checks = 0;
    int n_err    = 0;

    dds_sweep_ctrl #(.CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .f_start(f_start), .f_step(f_step), .dir_down(dir_down),
        .n_steps(n_steps), .dwell(dwell), .inv(inv), .continuous(continuous),
        .cfg(cfg), .busy(busy), .done(done), .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything derives from cycles elapsed since the accepted start.
    logic          m_run = 1'b0;
    int            m_t = 0;
    longint        m_fs, m_fst, m_n, m_d;
    logic          m_dn, m_inv, m_cont;
    logic [31:0]   e_cfg = '0;
    logic          e_busy = 1'b0, e_done = 1'b0;
    logic [CW-1:0] e_idx = '0;

    function automatic longint freq_at(input longint pos);
        longint v;
        v = m_dn ? m_fs - pos * m_fst : m_fs + pos * m_fst;
        if (v < 0) v = 0;
        if (v > 64'h3FFFFFFF) v = 64'h3FFFFFFF;
        return v;
    endfunction

    task automatic model_out();
        longint s, pos, idx;
        s   = m_t / m_d;
        idx = m_cont ? s % (m_n + 1) : s;
        pos = idx;
`ifdef DDS_SWEEP_PINGPONG_EN
        if (m_cont && m_n > 0) begin
            pos = s % (2 * m_n);
            if (pos > m_n) pos = 2 * m_n - pos;
            idx = (s <= m_n) ? s : ((s - m_n - 1) % m_n) + 1;
        end
`endif
        e_cfg  = {1'b1, m_inv, 30'(freq_at(pos))};
        e_idx  = CW'(idx);
        e_busy = 1'b1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0;
            e_cfg = '0; e_busy = 1'b0; e_done = 1'b0; e_idx = '0;
        end else begin
            e_done = 1'b0;
            if (!m_run) begin
                e_cfg[31] = 1'b0;
                e_busy    = 1'b0;
                if (start && !stop) begin
                    m_fs = longint'(f_start); m_fst = longint'(f_step);
                    m_n = longint'(n_steps); m_d = (dwell == 0) ? 1 : longint'(dwell);
                    m_dn = dir_down; m_inv = inv; m_cont = continuous;
                    m_run = 1'b1; m_t = 0;
                    model_out();
                end
            end else if (stop) begin
                m_run = 1'b0; e_cfg[31] = 1'b0; e_busy = 1'b0;
            end else begin
                m_t++;
                if (!m_cont && (m_t / m_d) > m_n) begin
                    m_run = 1'b0; e_done = 1'b1; e_cfg[31] = 1'b0; e_busy = 1'b0;
                end else begin
                    model_out();
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("cfg", longint'(cfg), longint'(e_cfg));
            check("busy", longint'(busy), longint'(e_busy));
            check("done", longint'(done), longint'(e_done));
            check("step_idx", longint'(step_idx), longint'(e_idx));
        end
    end

    // Launch a sweep, then scramble inputs to show they were latched.
    task automatic launch(input logic [29:0] fs, input logic [29:0] fst, input logic dn,
                          input int n, input int dw, input logic iv, input logic ct);
        @(negedge clk);
        f_start = fs; f_step = fst; dir_down = dn; n_steps = CW'(n); dwell = CW'(dw);
        inv = iv; continuous = ct; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        f_start = ~fs; f_step = fst + 30'd7; dir_down = ~dn; n_steps = CW'(n + 3);
        dwell = CW'(dw + 2); inv = ~iv; continuous = ~ct;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget && busy; i++) @(negedge clk);
        check("idle_timeout", longint'(busy), 0);
    endtask

    initial begin
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg", longint'(cfg), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_idx", longint'(step_idx), 0);

        // Basic up sweep
        launch(30'd1000, 30'd250, 1'b0, 3, 4, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            check("up_phase", longint'(cfg[29:0]), 1000 + 250 * (i / 4));
            check("up_on", longint'(cfg[31]), 1);
            @(negedge clk);
        end
        check("up_done", longint'(done), 1);
        check("up_off", longint'(cfg[31]), 0);
        check("up_final", longint'(cfg[29:0]), 1750);
        @(negedge clk);
        check("up_done_pulse", longint'(done), 0);

        // Down sweep with clamp
        launch(30'd100, 30'd60, 1'b1, 3, 2, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [29:0] dn_exp [4];
            dn_exp = '{30'd100, 30'd40, 30'd0, 30'd0};
            check("dn_phase", longint'(cfg[29:0]), longint'(dn_exp[i / 2]));
            @(negedge clk);
        end
        check("dn_done", longint'(done), 1);

        // Up saturation with inv
        launch(30'h3FFFFF00, 30'h80, 1'b0, 2, 1, 1'b1, 1'b0);
        check("sat0", longint'(cfg[29:0]), 64'h3FFFFF00);
        check("sat_inv", longint'(cfg[30]), 1);
        @(negedge clk);
        check("sat1", longint'(cfg[29:0]), 64'h3FFFFF80);
        @(negedge clk);
        check("sat2", longint'(cfg[29:0]), 64'h3FFFFFFF);
        check("sat_inv2", longint'(cfg[30]), 1);
        @(negedge clk);
        check("sat_done", longint'(done), 1);

        // Abort on the third RUN cycle
        launch(30'd500, 30'd10, 1'b0, 5, 3, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_busy", longint'(busy), 0);
        check("abort_on", longint'(cfg[31]), 0);
        check("abort_done", longint'(done), 0);

        // start together with stop in IDLE
        start = 1'b1; stop = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", longint'(busy), 0);

        // start during RUN is ignored
        launch(30'd2000, 30'd100, 1'b0, 2, 2, 1'b0, 1'b0);
        @(negedge clk);
        f_start = 30'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rerun_phase", longint'(cfg[29:0]), 2100);
        wait_idle(40);

        // n_steps = 0 single
        launch(30'd777, 30'd5, 1'b0, 0, 3, 1'b0, 1'b0);
        wait_idle(40);

        // Continuous, dwell 0, two frequencies
        launch(30'd10, 30'd5, 1'b0, 1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check("cont_phase", longint'(cfg[29:0]), (i % 2 == 0) ? 10 : 15);
            check("cont_busy", longint'(busy), 1);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("cont_stopped", longint'(busy), 0);

`ifdef DDS_SWEEP_PINGPONG_EN
        launch(30'd10, 30'd5, 1'b0, 2, 0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            int pp_exp [4];
            pp_exp = '{10, 15, 20, 15};
            check("pp_phase", longint'(cfg[29:0]), pp_exp[i % 4]);
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`endif

        // Async reset mid-RUN
        launch(30'd300, 30'd20, 1'b0, 4, 2, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cfg", longint'(cfg), 0);
        check("arst_busy", longint'(busy), 0);
        check("arst_idx", longint'(step_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep after reset recovers normally
        launch(30'd50, 30'd3, 1'b1, 2, 2, 1'b0, 1'b0);
        wait_idle(40);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
